// File: rtl/control_path_gen.sv
// ---------------------------------------------------------------------------
// control_path_gen
//   Moore control FSM for the s/y timer datapath. It sequences four regimes:
//   OFF, ELIST (a countdown list of s values with a per-point dwell), CNT
//   (free counting of s with y carry), and UPDATE (a fixed three-step y/s
//   update). All outputs are registered together with the state, so every
//   strobe is exactly one cycle long and is cleared again the next cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   on   [1:0]     regime request, looked at in OFF (and ELIST_WAIT for abort)
//   start          ELIST launch / CNT run enable
//   hold           pauses the ELIST dwell timer and CNT counting
//   y_inc          datapath flag: s+CNT_STEP wraps, y has to advance
//   regime [1:0]   0 OFF, 1 ELIST, 2 CNT, 3 UPDATE
//   active         high while the ELIST countdown runs
//   done           one-cycle pulse at the end of ELIST or UPDATE
//   elist_idx      number of ELIST points completed (saturating)
//   y_select_next  y next-value mux select (0 hold, 1 y+1, 2 alt)
//   s_step         operand for the s strobe
//   y_en/y_store_x y write enable; y<=x when y_store_x
//   s_en/s_add/s_zero  s strobe: zero loads s_step, add adds, else subtracts
// ---------------------------------------------------------------------------
module control_path_gen #(
    parameter int SW          = 4,
    parameter int ELIST_START = 6,
    parameter int ELIST_STEP  = 2,
    parameter int DWELL       = 4,
    parameter int CNT_STEP    = 1,
    parameter int IW          = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    on,
    input  logic          start,
    input  logic          hold,
    input  logic          y_inc,
    output logic [1:0]    regime,
    output logic          active,
    output logic          done,
    output logic [IW-1:0] elist_idx,
    output logic [1:0]    y_select_next,
    output logic [SW-1:0] s_step,
    output logic          y_en,
    output logic          y_store_x,
    output logic          s_en,
    output logic          s_add,
    output logic          s_zero
);

    localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SW-1:0] C_START = SW'(ELIST_START);
    localparam logic [SW-1:0] C_STEP  = SW'(ELIST_STEP);
    localparam logic [SW-1:0] C_CNT   = SW'(CNT_STEP);
    localparam logic [SW-1:0] C_ONE   = SW'(1);
    localparam logic [TW-1:0] C_TMAX  = TW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_EWAIT  = 3'd1,
        S_ERUN   = 3'd2,
        S_EDONE  = 3'd3,
        S_CNT    = 3'd4,
        S_UPLOAD = 3'd5,
        S_UPSEL  = 3'd6,
        S_UPDEC  = 3'd7
    } state_t;

    // Next countdown value: step down, but never below zero.
    function automatic logic [SW-1:0] clamp_sub(input logic [SW-1:0] v);
        return (v < C_STEP) ? '0 : (v - C_STEP);
    endfunction

    // Point counter stops at all-ones instead of wrapping.
    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] x);
        return (&x) ? x : (x + 1'b1);
    endfunction

    state_t        r_state;
    logic [SW-1:0] r_v;
    logic [TW-1:0] r_timer;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_regime;
    logic          r_active;
    logic          r_done;
    logic [1:0]    r_ysel;
    logic [SW-1:0] r_s_step;
    logic          r_y_en;
    logic          r_y_store_x;
    logic          r_s_en;
    logic          r_s_add;
    logic          r_s_zero;

    state_t        w_state_nxt;
    logic [SW-1:0] w_v_nxt;
    logic [SW-1:0] w_v_dec;
    logic [TW-1:0] w_timer_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [1:0]    w_regime_nxt;
    logic          w_active_nxt;
    logic          w_done_nxt;
    logic [1:0]    w_ysel_nxt;
    logic [SW-1:0] w_s_step_nxt;
    logic          w_y_en_nxt;
    logic          w_y_store_x_nxt;
    logic          w_s_en_nxt;
    logic          w_s_add_nxt;
    logic          w_s_zero_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_v_nxt         = r_v;
        w_v_dec         = clamp_sub(r_v);
        w_timer_nxt     = r_timer;
        w_idx_nxt       = r_idx;
        w_regime_nxt    = 2'd0;
        w_active_nxt    = 1'b0;
        w_done_nxt      = 1'b0;
        w_ysel_nxt      = 2'd0;
        w_s_step_nxt    = '0;
        w_y_en_nxt      = 1'b0;
        w_y_store_x_nxt = 1'b0;
        w_s_en_nxt      = 1'b0;
        w_s_add_nxt     = 1'b0;
        w_s_zero_nxt    = 1'b0;

        // Strobes are computed on the transition so they appear in the
        // same cycle as the state they belong to.
        unique case (r_state)
            S_OFF: begin
                unique case (on)
                    2'd0: w_state_nxt = S_OFF;
                    2'd1: w_state_nxt = S_EWAIT;
                    2'd2: w_state_nxt = S_CNT;
                    default: begin
                        w_state_nxt     = S_UPLOAD;
                        w_y_en_nxt      = 1'b1;
                        w_y_store_x_nxt = 1'b1;
                    end
                endcase
            end
            S_EWAIT: begin
                if (start) begin
                    w_state_nxt  = S_ERUN;
                    w_v_nxt      = C_START;
                    w_timer_nxt  = C_TMAX;
                    w_idx_nxt    = '0;
                    w_s_en_nxt   = 1'b1;
                    w_s_zero_nxt = 1'b1;
                    w_s_step_nxt = C_START;
                end else if (on == 2'd0) begin
                    w_state_nxt = S_OFF;
                end
            end
            S_ERUN: begin
                if (!hold) begin
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - 1'b1;
                    end else if (r_v == '0) begin
                        w_state_nxt = S_EDONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Step operand is the actual drop, so the last
                        // point clamps cleanly to zero.
                        w_v_nxt      = w_v_dec;
                        w_s_en_nxt   = 1'b1;
                        w_s_step_nxt = r_v - w_v_dec;
                        w_idx_nxt    = sat_inc(r_idx);
                        w_timer_nxt  = C_TMAX;
                    end
                end
            end
            S_EDONE: begin
                w_state_nxt = S_OFF;
            end
            S_CNT: begin
                // Dropping start leaves immediately, even while held.
                if (!start) begin
                    w_state_nxt = S_OFF;
                end else if (!hold) begin
                    w_s_en_nxt   = 1'b1;
                    w_s_add_nxt  = 1'b1;
                    w_s_step_nxt = C_CNT;
                    if (y_inc) begin
                        w_y_en_nxt = 1'b1;
                        w_ysel_nxt = 2'd1;
                    end
                end
            end
            S_UPLOAD: begin
                w_state_nxt = S_UPSEL;
                w_y_en_nxt  = 1'b1;
                w_ysel_nxt  = 2'd2;
            end
            S_UPSEL: begin
                w_state_nxt  = S_UPDEC;
                w_s_en_nxt   = 1'b1;
                w_s_step_nxt = C_ONE;
                w_done_nxt   = 1'b1;
            end
            S_UPDEC: begin
                w_state_nxt = S_OFF;
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase

        unique case (w_state_nxt)
            S_EWAIT, S_EDONE:           w_regime_nxt = 2'd1;
            S_ERUN: begin
                w_regime_nxt = 2'd1;
                w_active_nxt = 1'b1;
            end
            S_CNT:                      w_regime_nxt = 2'd2;
            S_UPLOAD, S_UPSEL, S_UPDEC: w_regime_nxt = 2'd3;
            default:                    w_regime_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_OFF;
            r_v         <= '0;
            r_timer     <= '0;
            r_idx       <= '0;
            r_regime    <= 2'd0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_ysel      <= 2'd0;
            r_s_step    <= '0;
            r_y_en      <= 1'b0;
            r_y_store_x <= 1'b0;
            r_s_en      <= 1'b0;
            r_s_add     <= 1'b0;
            r_s_zero    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_v         <= w_v_nxt;
            r_timer     <= w_timer_nxt;
            r_idx       <= w_idx_nxt;
            r_regime    <= w_regime_nxt;
            r_active    <= w_active_nxt;
            r_done      <= w_done_nxt;
            r_ysel      <= w_ysel_nxt;
            r_s_step    <= w_s_step_nxt;
            r_y_en      <= w_y_en_nxt;
            r_y_store_x <= w_y_store_x_nxt;
            r_s_en      <= w_s_en_nxt;
            r_s_add     <= w_s_add_nxt;
            r_s_zero    <= w_s_zero_nxt;
        end
    end

    assign regime        = r_regime;
    assign active        = r_active;
    assign done          = r_done;
    assign elist_idx     = r_idx;
    assign y_select_next = r_ysel;
    assign s_step        = r_s_step;
    assign y_en          = r_y_en;
    assign y_store_x     = r_y_store_x;
    assign s_en          = r_s_en;
    assign s_add         = r_s_add;
    assign s_zero        = r_s_zero;

endmodule

// File: tb/tb_control_path_gen.sv
// ---------------------------------------------------------------------------
// tb_control_path_gen
//   Two instances: defaults (6/2/4) and a 5/2/3 countdown that exercises the
//   clamped last step. The driver plans each transaction, asks the reference
//   model for the expected per-cycle output vector of every non-idle cycle,
//   queues them, then drives the inputs. A monitor compares on each falling
//   edge and flags unexpected activity or missing expected cycles.
// ---------------------------------------------------------------------------
module tb_control_path_gen;
    localparam int SW = 4;
    localparam int IW = 3;

    typedef struct packed {
        logic [1:0]    regime;
        logic          active;
        logic          done;
        logic [IW-1:0] idx;
        logic [1:0]    ysel;
        logic [SW-1:0] step;
        logic          y_en;
        logic          y_sx;
        logic          s_en;
        logic          s_add;
        logic          s_zero;
    } vec_t;

    typedef struct {
        int   cyc;
        vec_t v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] on = 2'd0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       y_inc = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] a_regime, b_regime, a_ysel, b_ysel;
    logic a_active, b_active, a_done, b_done, a_yen, b_yen, a_ysx, b_ysx;
    logic a_sen, b_sen, a_sadd, b_sadd, a_szero, b_szero;
    logic [IW-1:0] a_idx, b_idx;
    logic [SW-1:0] a_step, b_step;

    control_path_gen #(.SW(SW), .ELIST_START(6), .ELIST_STEP(2), .DWELL(4), .CNT_STEP(1), .IW(IW)) dut_a (
        .clk(clk), .rst(rst), .on(on), .start(start), .hold(hold), .y_inc(y_inc),
        .regime(a_regime), .active(a_active), .done(a_done), .elist_idx(a_idx),
        .y_select_next(a_ysel), .s_step(a_step), .y_en(a_yen), .y_store_x(a_ysx),
        .s_en(a_sen), .s_add(a_sadd), .s_zero(a_szero));

    control_path_gen #(.SW(SW), .ELIST_START(5), .ELIST_STEP(2), .DWELL(3), .CNT_STEP(1), .IW(IW)) dut_b (
        .clk(clk), .rst(rst), .on(on), .start(start), .hold(hold), .y_inc(y_inc),
        .regime(b_regime), .active(b_active), .done(b_done), .elist_idx(b_idx),
        .y_select_next(b_ysel), .s_step(b_step), .y_en(b_yen), .y_store_x(b_ysx),
        .s_en(b_sen), .s_add(b_sadd), .s_zero(b_szero));

    vec_t act [2];
    assign act[0] = {a_regime, a_active, a_done, a_idx, a_ysel, a_step, a_yen, a_ysx, a_sen, a_sadd, a_szero};
    assign act[1] = {b_regime, b_active, b_done, b_idx, b_ysel, b_step, b_yen, b_ysx, b_sen, b_sadd, b_szero};

    int   checks = 0;
    int   failures = 0;
    exp_t sq [2][$];
    int   last_idx [2] = '{0, 0};
    int   p_start [2] = '{6, 5};
    int   p_step  [2] = '{2, 2};
    int   p_dwell [2] = '{4, 3};
    int   hs = 0;
    int   hl = 0;

    function automatic vec_t mk(int rg, int ac, int dn, int ix, int ys, int st,
                                int ye, int yx, int se, int sa, int sz);
        vec_t r;
        r.regime = 2'(rg);  r.active = 1'(ac); r.done = 1'(dn); r.idx = IW'(ix);
        r.ysel   = 2'(ys);  r.step   = SW'(st); r.y_en = 1'(ye); r.y_sx = 1'(yx);
        r.s_en   = 1'(se);  r.s_add  = 1'(sa);  r.s_zero = 1'(sz);
        return r;
    endfunction

    function automatic bit held(int t);
        return (t >= hs) && (t < hs + hl);
    endfunction

    task automatic push(int d, int c, vec_t v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sq[d].push_back(e);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // ELIST reference: each point lasts DWELL un-held cycles counted from its
    // strobe cycle; the following cycle carries the next strobe (or done).
    task automatic model_elist(int d, int c0, output int tdone);
        int v, vn, idx, t, rem;
        bit fin, fire;
        push(d, c0 + 1, mk(1, 0, 0, last_idx[d], 0, 0, 0, 0, 0, 0, 0));
        t = c0 + 2;
        v = p_start[d];
        idx = 0;
        push(d, t, mk(1, 1, 0, 0, 0, v, 0, 0, 1, 0, 1));
        rem = p_dwell[d];
        fin = 1'b0;
        while (!fin) begin
            fire = !held(t) && (rem == 1);
            if (!held(t)) rem--;
            t++;
            if (fire) begin
                if (v == 0) begin
                    push(d, t, mk(1, 0, 1, idx, 0, 0, 0, 0, 0, 0, 0));
                    fin = 1'b1;
                end else begin
                    vn = (v < p_step[d]) ? 0 : v - p_step[d];
                    if (idx < (1 << IW) - 1) idx++;
                    push(d, t, mk(1, 1, 0, idx, 0, v - vn, 0, 0, 1, 0, 0));
                    v = vn;
                    rem = p_dwell[d];
                end
            end else begin
                push(d, t, mk(1, 1, 0, idx, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        last_idx[d] = idx;
        tdone = t;
    endtask

    task automatic run_elist(int hoff, int hlen);
        int c0, td0, td1, tend;
        c0 = cyc;
        hs = c0 + 2 + hoff;
        hl = hlen;
        model_elist(0, c0, td0);
        model_elist(1, c0, td1);
        tend = (td0 > td1) ? td0 : td1;
        on = 2'd1; start = 1'b0; hold = 1'b0;
        step_cycle();
        start = 1'b1;
        step_cycle();
        on = 2'd0;
        while (cyc <= tend) begin
            start = 1'($urandom_range(0, 1));
            hold  = held(cyc);
            step_cycle();
        end
        start = 1'b0; hold = 1'b0;
        step_cycle();
        step_cycle();
    endtask

    task automatic run_cnt(int n, bit rnd, int yat);
        int c0, t, k;
        bit h [64];
        bit y [64];
        c0 = cyc;
        for (int i = 1; i <= n; i++) begin
            h[i] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            y[i] = rnd ? 1'($urandom_range(0, 1)) : (i == yat);
        end
        for (int d = 0; d < 2; d++) begin
            push(d, c0 + 1, mk(2, 0, 0, last_idx[d], 0, 0, 0, 0, 0, 0, 0));
            for (t = c0 + 2; t <= c0 + n + 1; t++) begin
                k = t - 1 - c0;
                if (!h[k])
                    push(d, t, mk(2, 0, 0, last_idx[d], y[k] ? 1 : 0, 1, int'(y[k]), 0, 1, 1, 0));
                else
                    push(d, t, mk(2, 0, 0, last_idx[d], 0, 0, 0, 0, 0, 0, 0));
            end
        end
        on = 2'd2; start = 1'b1; hold = 1'b0; y_inc = 1'b0;
        step_cycle();
        on = 2'd0;
        for (int i = 1; i <= n; i++) begin
            hold = h[i]; y_inc = y[i];
            step_cycle();
        end
        start = 1'b0; hold = 1'b1; y_inc = 1'b1;
        step_cycle();
        hold = 1'b0; y_inc = 1'b0;
        step_cycle();
    endtask

    task automatic run_update();
        int c0;
        c0 = cyc;
        for (int d = 0; d < 2; d++) begin
            push(d, c0 + 1, mk(3, 0, 0, last_idx[d], 0, 0, 1, 1, 0, 0, 0));
            push(d, c0 + 2, mk(3, 0, 0, last_idx[d], 2, 0, 1, 0, 0, 0, 0));
            push(d, c0 + 3, mk(3, 0, 1, last_idx[d], 0, 1, 0, 0, 1, 0, 0));
        end
        on = 2'd3; start = 1'($urandom_range(0, 1)); hold = 1'($urandom_range(0, 1));
        step_cycle();
        on = 2'd0;
        repeat (4) begin
            start = 1'($urandom_range(0, 1)); hold = 1'($urandom_range(0, 1));
            step_cycle();
        end
        start = 1'b0; hold = 1'b0;
    endtask

    task automatic run_abort();
        int c0, k;
        c0 = cyc;
        k = $urandom_range(1, 4);
        for (int d = 0; d < 2; d++)
            for (int t = c0 + 1; t <= c0 + k; t++)
                push(d, t, mk(1, 0, 0, last_idx[d], 0, 0, 0, 0, 0, 0, 0));
        on = 2'd1; start = 1'b0; hold = 1'($urandom_range(0, 1));
        step_cycle();
        repeat (k - 1) step_cycle();
        on = 2'd0;
        step_cycle();
        hold = 1'b0;
        step_cycle();
    endtask

    task automatic chk_zero(string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== '0) begin
                failures++;
                $display("FAIL %s dut%0d got=%h exp=%h", name, d, act[d], vec_t'(0));
            end
        end
    endtask

    // Scoreboard monitor.
    exp_t em;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            while (sq[d].size() > 0 && sq[d][0].cyc < cyc) begin
                em = sq[d].pop_front();
                checks++; failures++;
                $display("FAIL missed dut%0d cyc=%0d got=none exp=%h", d, em.cyc, em.v);
            end
            if (sq[d].size() > 0 && sq[d][0].cyc == cyc) begin
                em = sq[d].pop_front();
                checks++;
                if (act[d] !== em.v) begin
                    failures++;
                    $display("FAIL outvec dut%0d cyc=%0d got=%h exp=%h", d, cyc, act[d], em.v);
                end
            end else if ((act[d] & ~vec_t'({2'b00, 1'b0, 1'b0, {IW{1'b1}}, 2'b00, {SW{1'b0}}, 5'b0})) != '0) begin
                checks++; failures++;
                $display("FAIL unexpected dut%0d cyc=%0d got=%h exp=idle", d, cyc, act[d]);
            end
        end
    end

    initial begin
        int c0, dummy;
        #2 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_zero("reset_state");
        rst = 1'b1;
        step_cycle();

        run_elist(0, 0);            // plain countdown
        run_elist(5, 5);            // 5-cycle hold in the second point
        run_cnt(8, 1'b0, 3);        // 8 counts, one y carry
        run_update();

        // Reset in the middle of a countdown: everything clears, no done.
        c0 = cyc; hs = 0; hl = 0;
        model_elist(0, c0, dummy);
        model_elist(1, c0, dummy);
        on = 2'd1; step_cycle();
        start = 1'b1; step_cycle();
        on = 2'd0; start = 1'b0;
        repeat (6) step_cycle();
        #2 rst = 1'b0;
        #1 chk_zero("async_reset");
        sq[0].delete(); sq[1].delete();
        last_idx[0] = 0; last_idx[1] = 0;
        step_cycle();
        chk_zero("reset_held");
        rst = 1'b1;
        step_cycle();
        run_elist(0, 0);            // restart after reset

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: run_elist($urandom_range(0, 20), $urandom_range(0, 6));
                1: run_cnt($urandom_range(1, 12), 1'b1, 0);
                2: run_update();
                default: run_abort();
            endcase
            repeat ($urandom_range(0, 2)) step_cycle();
        end

        for (int i = 0; i < 50 && (sq[0].size() > 0 || sq[1].size() > 0); i++) step_cycle();
        step_cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sq[d].size() != 0) begin
                failures++;
                $display("FAIL drain dut%0d got=%0d pending exp=0", d, sq[d].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
